hex_upd_ctrl: RTL
=================

HEX_UPD_CTRL -- requirements
Module: hex_upd_ctrl

Interface
REQ-001 Parameter DIGIT_BASE, default 32'h00: peripheral offset of HEX0; HEXn = DIGIT_BASE + 4*n.
REQ-002 Parameter MASK_ADDR, default 32'h20: peripheral offset of the bitmask register.
REQ-003 One clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_i  in  1  async active-high reset.
REQ-006 core_req_i  in  1  core bus request.
REQ-007 core_we_i  in  1  core write enable.
REQ-008 core_addr_i  in  32  core offset.
REQ-009 core_wdata_i  in  32  core write data.
REQ-010 core_ready_o  out  1  core request granted this cycle.
REQ-011 core_rdata_o  out  32  read data, valid the cycle after a granted read.
REQ-012 upd_start_i  in  1  one-cycle start of a display update.
REQ-013 upd_value_i  in  32  value to show, 8 nibbles, nibble n to HEXn.
REQ-014 upd_blank_i  in  1  leading-zero blanking enable.
REQ-015 upd_busy_o  out  1  sequencer active.
REQ-016 upd_done_o  out  1  one-cycle pulse when the update completes.
REQ-017 req_o, write_enable_o  out  1 each  peripheral request and write strobe.
REQ-018 addr_o, write_data_o  out  32 each  peripheral offset and write data.
REQ-019 read_data_i  in  32  peripheral read data, registered, 1-cycle latency.

Function
REQ-020 The sequencer SHALL have states IDLE, DIG, MASK, DONE.
REQ-021 In IDLE, upd_start_i SHALL capture upd_value_i and upd_blank_i, clear a 3-bit digit index, and go to DIG; start in any other state SHALL be ignored.
REQ-022 DIG SHALL request a write of {28'b0, nibble[idx]} to DIGIT_BASE+4*idx; on grant, idx increments; after the idx=7 grant, the state SHALL go to MASK.
REQ-023 MASK SHALL request a write of {24'b0, mask} to MASK_ADDR; on grant, the state SHALL go to DONE.
REQ-024 mask SHALL be 8'hFF when blank is 0; when blank is 1, bits 0..k SHALL be set, where k is the highest nonzero nibble index, and value 0 SHALL give 8'h01.
REQ-025 DONE SHALL assert upd_done_o for exactly one cycle and return to IDLE.
REQ-026 upd_busy_o SHALL be 1 in DIG, MASK and DONE, and 0 in IDLE.
REQ-027 Per cycle, at most one requester SHALL be granted, and req_o SHALL be 1 exactly when a grant occurs.
REQ-028 On a grant, addr_o, write_data_o and write_enable_o SHALL come from the granted requester.
REQ-029 When no grant occurs, addr_o, write_data_o and write_enable_o SHALL be 0.
REQ-030 With only one requester pending, that requester SHALL be granted in the same cycle.
REQ-031 Arbitration with both pending SHALL be round-robin on a last_grant register: the requester not granted in the previous contested cycle wins.
REQ-032 last_grant SHALL update only on contested cycles.
REQ-033 core_ready_o SHALL be combinational and equal 1 in the cycle the core is granted.
REQ-034 A core request not granted SHALL be held by the core; the block SHALL not queue it.
REQ-035 core_rdata_o SHALL equal read_data_i, and its value SHALL be defined only in the cycle after a granted core read.
REQ-036 Sequencer transfers SHALL always be writes, so read_data_i is never consumed by the sequencer.
REQ-037 A core write to a HEX or mask offset during an update SHALL be forwarded unmodified; the later sequencer writes overwrite it.

Reset
REQ-038 rst_i SHALL immediately force state IDLE, idx 0, captured value 0, last_grant=sequencer (core wins the first contest), and upd_busy_o=upd_done_o=0.
REQ-039 rst_i SHALL immediately force req_o=write_enable_o=0, addr_o=write_data_o=0, and core_ready_o=0.
REQ-040 Reset mid-update SHALL abandon the sequence with no completion pulse and no further writes; already-written digits stay as written.

Verification
REQ-041 Start with value 32'h1234_5678 and blank=0, no core traffic -> 9 consecutive writes: 0x00..0x1C with data 8,7,6,5,4,3,2,1, then 0x20 with data 0xFF; done pulses on cycle 10; busy spans cycles 1-10.
REQ-042 Start with value 32'h0000_00A0 and blank=1 -> final mask write is 0x03; value 0 with blank=1 -> mask 0x01.
REQ-043 Core writes continuously during an update -> grants alternate core, seq, core, ...; all 9 sequencer writes are issued and the update completes within 18 grant cycles.
REQ-044 Core read of 0x04 granted while idle -> core_ready_o=1 that cycle; next cycle core_rdata_o equals read_data_i.
REQ-045 Start pulsed again while busy -> no restart; exactly one done pulse; the data written is from the first value.
REQ-046 rst_i asserted after the 3rd digit write -> outputs are 0 immediately; no done pulse; a fresh start after release runs the full 9-write sequence.

Source files
------------

// File: rtl/hex_upd_if.sv
// hex_upd_if
// Groups every non-clock signal of hex_upd_ctrl.
//   core_*    : core bus port (request/write/address/data in, ready/read data out)
//   upd_*     : display update control (start/value/blank in, busy/done out)
//   req_o, write_enable_o, addr_o, write_data_o, read_data_i : peripheral port
// The slave modport is the controller's view; master is the environment's view.
interface hex_upd_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic        core_ready_o;
    logic [31:0] core_rdata_o;

    logic        upd_start_i;
    logic [31:0] upd_value_i;
    logic        upd_blank_i;
    logic        upd_busy_o;
    logic        upd_done_o;

    logic        req_o;
    logic        write_enable_o;
    logic [31:0] addr_o;
    logic [31:0] write_data_o;
    logic [31:0] read_data_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_ready_o, core_rdata_o,
        input  upd_start_i, upd_value_i, upd_blank_i,
        output upd_busy_o, upd_done_o,
        output req_o, write_enable_o, addr_o, write_data_o,
        input  read_data_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_ready_o, core_rdata_o,
        output upd_start_i, upd_value_i, upd_blank_i,
        input  upd_busy_o, upd_done_o,
        input  req_o, write_enable_o, addr_o, write_data_o,
        output read_data_i
    );
endinterface

// File: rtl/hex_upd_ctrl.sv
// hex_upd_ctrl
// Writes an 8-digit hex value to a seven-segment peripheral (one register per
// digit, then a digit-enable bitmask) while sharing the peripheral port with a
// core bus through a two-way round-robin arbiter.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : hex_upd_if.slave (core port, update control, peripheral port)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for upd_start_i
// DIG    | writing digit idx to DIGIT_BASE + 4*idx
// MASK   | writing the digit-enable bitmask to MASK_ADDR
// DONE   | one-cycle completion pulse, then back to IDLE
module hex_upd_ctrl #(
    parameter logic [31:0] DIGIT_BASE = 32'h00,
    parameter logic [31:0] MASK_ADDR  = 32'h20
) (
    input  logic     clk_i,
    input  logic     rst_i,
    hex_upd_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIG  = 2'd1;
    localparam logic [1:0] S_MASK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q;
    logic [2:0]  idx_q;
    logic [31:0] value_q;
    logic        blank_q;
    logic        last_core_q;   // 1: core won the previous contested cycle

    logic        seq_req;
    logic        core_req;
    logic        contested;
    logic        grant_core;
    logic        grant_seq;
    logic [31:0] seq_addr;
    logic [31:0] seq_data;
    logic [7:0]  nib_nz;
    logic [7:0]  mask;

    // Requests are gated by reset so every output drops the moment rst_i rises.
    assign seq_req    = !rst_i && ((state_q == S_DIG) || (state_q == S_MASK));
    assign core_req   = !rst_i && bus.core_req_i;
    assign contested  = seq_req && core_req;
    assign grant_core = core_req && (!seq_req || !last_core_q);
    assign grant_seq  = seq_req && (!core_req || last_core_q);

    // With blanking, enable digits 0..k where k is the highest nonzero nibble;
    // digit 0 is always enabled so a zero value still shows "0".
    always_comb begin
        nib_nz = 8'h00;
        mask   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            nib_nz[i] = |value_q[4*i +: 4];
        end
        mask[7] = nib_nz[7];
        for (int i = 6; i >= 0; i--) begin
            mask[i] = mask[i+1] | nib_nz[i];
        end
        mask[0] = 1'b1;
        if (!blank_q) begin
            mask = 8'hFF;
        end
    end

    always_comb begin
        seq_addr = MASK_ADDR;
        seq_data = {24'd0, mask};
        if (state_q == S_DIG) begin
            seq_addr = DIGIT_BASE + {27'd0, idx_q, 2'b00};
            seq_data = {28'd0, value_q[{idx_q, 2'b00} +: 4]};
        end
    end

    always_comb begin
        bus.req_o          = grant_core || grant_seq;
        bus.write_enable_o = 1'b0;
        bus.addr_o         = 32'd0;
        bus.write_data_o   = 32'd0;
        if (grant_core) begin
            bus.write_enable_o = bus.core_we_i;
            bus.addr_o         = bus.core_addr_i;
            bus.write_data_o   = bus.core_wdata_i;
        end else if (grant_seq) begin
            bus.write_enable_o = 1'b1;
            bus.addr_o         = seq_addr;
            bus.write_data_o   = seq_data;
        end
    end

    assign bus.core_ready_o = grant_core;
    // Peripheral read data is already registered; only meaningful the cycle
    // after a granted core read.
    assign bus.core_rdata_o = bus.read_data_i;
    assign bus.upd_busy_o   = (state_q != S_IDLE);
    assign bus.upd_done_o   = (state_q == S_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_core_q <= 1'b0;
        end else if (contested) begin
            last_core_q <= grant_core;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            value_q <= 32'd0;
            blank_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.upd_start_i) begin
                        value_q <= bus.upd_value_i;
                        blank_q <= bus.upd_blank_i;
                        idx_q   <= 3'd0;
                        state_q <= S_DIG;
                    end
                end
                S_DIG: begin
                    if (grant_seq) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_MASK;
                        end
                    end
                end
                S_MASK: begin
                    if (grant_seq) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
